// File: rtl/fft_frame_serializer.sv
// rtl/fft_frame_serializer.sv - buffers one 16-sample complex frame and streams it out one lane per handshake
module fft_frame_serializer #(
   parameter int WORD_SIZE = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [16*WORD_SIZE-1:0]   in_re,
   input  logic [16*WORD_SIZE-1:0]   in_im,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WORD_SIZE-1:0]      out_re,
   output logic [WORD_SIZE-1:0]      out_im,
   output logic [3:0]                out_idx,
   output logic                      out_last,
   output logic [7:0]                frame_cnt
);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [WORD_SIZE-1:0] lane_re [16];
   logic [WORD_SIZE-1:0] lane_im [16];
   logic [3:0]           idx;
   logic                 accept;
   logic                 handshake;
   logic                 last_hs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // in_ready reopens in STREAM only on the final handshake, so a waiting frame loads with no bubble
   always_comb begin
      state_nxt = state;
      out_valid = (state == STREAM);
      handshake = out_valid & out_ready;
      out_last  = out_valid & (idx == 4'd15);
      last_hs   = handshake & out_last;
      in_ready  = (state == IDLE) | last_hs;
      accept    = in_valid & in_ready;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (last_hs && !accept) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // idx parks at 15 after the last sample so IDLE keeps showing the final lane
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= 4'd0;
         for (int k = 0; k < 16; k++) begin
            lane_re[k] <= '0;
            lane_im[k] <= '0;
         end
      end else if (accept) begin
         idx <= 4'd0;
         for (int k = 0; k < 16; k++) begin
            lane_re[k] <= in_re[k*WORD_SIZE +: WORD_SIZE];
            lane_im[k] <= in_im[k*WORD_SIZE +: WORD_SIZE];
         end
      end else if (handshake && (idx != 4'd15)) begin
         idx <= idx + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= 8'd0;
      end else if (last_hs) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end

   assign out_re  = lane_re[idx];
   assign out_im  = lane_im[idx];
   assign out_idx = idx;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// tb/tb_fft_frame_serializer.sv - directed stimulus with a queue model of the frame serializer
module tb_fft_frame_serializer;

   localparam int W = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [16*W-1:0] in_re = '0;
   logic [16*W-1:0] in_im = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [W-1:0]    out_re;
   logic [W-1:0]    out_im;
   logic [3:0]      out_idx;
   logic            out_last;
   logic [7:0]      frame_cnt;

   fft_frame_serializer #(.WORD_SIZE(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_re(in_re), .in_im(in_im),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_re(out_re), .out_im(out_im),
      .out_idx(out_idx), .out_last(out_last),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] re;
      logic [W-1:0] im;
      logic [3:0]   idx;
   } sample_t;

   sample_t      q[$];
   logic [7:0]   m_fc = 8'd0;
   logic [W-1:0] last_re = '0;
   logic [W-1:0] last_im = '0;
   logic [3:0]   last_idx = '0;
   int           hs_total = 0;
   int           dead_seen = 0;
   int           total = 0;
   int           bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: a frame is 16 queued samples; the head is what must be on the output
   always @(negedge clk) begin
      logic    exp_v;
      logic    exp_rdy;
      sample_t e;
      if (!rst_n) begin
         q.delete();
         m_fc     = 8'd0;
         last_re  = '0;
         last_im  = '0;
         last_idx = '0;
      end else begin
         exp_v = (q.size() != 0);
         chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
         if (exp_v) begin
            chk("out_re", {16'd0, out_re}, {16'd0, q[0].re});
            chk("out_im", {16'd0, out_im}, {16'd0, q[0].im});
            chk("out_idx", {28'd0, out_idx}, {28'd0, q[0].idx});
            chk("out_last", {31'd0, out_last}, {31'd0, q[0].idx == 4'd15});
            exp_rdy = out_ready && (q[0].idx == 4'd15);
         end else begin
            chk("idle_re", {16'd0, out_re}, {16'd0, last_re});
            chk("idle_im", {16'd0, out_im}, {16'd0, last_im});
            chk("idle_idx", {28'd0, out_idx}, {28'd0, last_idx});
            chk("idle_last", {31'd0, out_last}, 32'd0);
            exp_rdy = 1'b1;
         end
         chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
         chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, m_fc});
         if (out_valid && (out_re == 16'hDEAD || out_im == 16'hDEAD)) dead_seen++;
         if (exp_v && out_ready) begin
            e        = q.pop_front();
            last_re  = e.re;
            last_im  = e.im;
            last_idx = e.idx;
            hs_total++;
            if (e.idx == 4'd15) m_fc = m_fc + 8'd1;
         end
         if (in_valid && exp_rdy) begin
            for (int k = 0; k < 16; k++) begin
               e.re  = in_re[k*W +: W];
               e.im  = in_im[k*W +: W];
               e.idx = 4'(k);
               q.push_back(e);
            end
         end
      end
   end

   task automatic set_data(input logic [W-1:0] re_base, input logic [W-1:0] im_base, input logic im_neg);
      for (int k = 0; k < 16; k++) begin
         in_re[k*W +: W] = re_base + W'(k);
         in_im[k*W +: W] = im_neg ? (im_base - W'(k)) : (im_base + W'(k));
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_re", {16'd0, out_re}, 32'd0);
      chk("rst_im", {16'd0, out_im}, 32'd0);
      chk("rst_idx", {28'd0, out_idx}, 32'd0);
      chk("rst_last", {31'd0, out_last}, 32'd0);
      chk("rst_fcnt", {24'd0, frame_cnt}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic send_frame();
      int n = 0;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 100);
      chk("send_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idx(input logic [3:0] target);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(out_valid && out_idx == target) && n < 100);
      chk("idx_timeout", {28'd0, out_idx}, {28'd0, target});
   endtask

   task automatic drain();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (out_valid && n < 200);
      chk("drain_timeout", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      int h0;
      int n;
      do_reset();

      // basic frame: re=k, im=-k
      set_data(16'h0000, 16'h0000, 1'b1);
      send_frame();
      @(negedge clk);
      chk("basic_first_valid", {31'd0, out_valid}, 32'd1);
      chk("basic_first_re", {16'd0, out_re}, 32'h0);
      repeat (14) @(negedge clk);
      chk("basic_idx14_im", {16'd0, out_im}, 32'hFFF2);
      chk("basic_idx14_last", {31'd0, out_last}, 32'd0);
      @(negedge clk);
      chk("basic_last", {31'd0, out_last}, 32'd1);
      chk("basic_last_re", {16'd0, out_re}, 32'd15);
      @(negedge clk);
      chk("basic_done_valid", {31'd0, out_valid}, 32'd0);
      chk("basic_fcnt", {24'd0, frame_cnt}, 32'd1);

      // backpressure: out_ready alternates
      do_reset();
      set_data(16'h1200, 16'h3400, 1'b0);
      send_frame();
      h0 = hs_total;
      out_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(posedge clk); #1;
         out_ready = ~out_ready;
      end
      out_ready = 1'b1;
      chk("bp_handshakes", 32'(hs_total - h0), 32'd16);
      chk("bp_fcnt", {24'd0, frame_cnt}, 32'd1);

      // back-to-back frames A then B
      do_reset();
      set_data(16'h0A00, 16'h5A00, 1'b0);
      send_frame();
      set_data(16'h0B00, 16'h5B00, 1'b0);
      in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 100);
      chk("b2b_a_last", {31'd0, out_last}, 32'd1);
      chk("b2b_a_idx", {28'd0, out_idx}, 32'd15);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_b0_re", {16'd0, out_re}, 32'h0B00);
      chk("b2b_b0_idx", {28'd0, out_idx}, 32'd0);
      chk("b2b_fcnt1", {24'd0, frame_cnt}, 32'd1);
      drain();
      chk("b2b_fcnt2", {24'd0, frame_cnt}, 32'd2);

      // busy-ignore: DEAD data offered while A is mid-stream
      do_reset();
      set_data(16'h0C00, 16'h7C00, 1'b1);
      send_frame();
      wait_idx(4'd3);
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int k = 0; k < 16; k++) begin
         in_re[k*W +: W] = 16'hDEAD;
         in_im[k*W +: W] = 16'hDEAD;
      end
      in_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1 out_ready = 1'b1;
      wait_idx(4'd10);
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();
      chk("busy_dead_seen", 32'(dead_seen), 32'd0);
      chk("busy_fcnt", {24'd0, frame_cnt}, 32'd1);

      // reset mid-frame
      do_reset();
      set_data(16'h0100, 16'h0200, 1'b0);
      send_frame();
      set_data(16'h0300, 16'h0400, 1'b0);
      send_frame();
      wait_idx(4'd5);
      chk("mid_fcnt_before", {24'd0, frame_cnt}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_fcnt", {24'd0, frame_cnt}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      set_data(16'h0E00, 16'h0F00, 1'b0);
      send_frame();
      @(negedge clk);
      chk("mid_new_idx", {28'd0, out_idx}, 32'd0);
      chk("mid_new_re", {16'd0, out_re}, 32'h0E00);
      drain();

      // wrap: 256 frames streamed back to back
      do_reset();
      set_data(16'h2000, 16'h3000, 1'b0);
      in_valid = 1'b1;
      for (int f = 0; f < 256; f++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(out_valid && out_last) && n < 100);
         @(posedge clk); #1;
         if (f == 254) chk("wrap_255", {24'd0, frame_cnt}, 32'd255);
         if (f == 255) chk("wrap_0", {24'd0, frame_cnt}, 32'd0);
      end
      in_valid = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
